// File: rtl/vsa_dmem_wbuf.sv
// vsa_dmem_wbuf - data-side memory stage for the 12-bit VSA core.
//
// A local scratchpad of 2**AW words answers loads combinationally. Every store
// writes the scratchpad and is also queued in a DEPTH-entry FIFO store buffer.
// The buffer drains to a backing store over a req/ack handshake. The core is
// never stalled. A store that arrives while the buffer is full and not being
// popped is dropped from the buffer, and this sets a sticky overflow flag.
//
// Ports:
//   clock     master clock; all state changes on posedge
//   reset     synchronous, active-high; clears scratchpad, pointers, count, overflow
//   addr      data address from the core (ALUOutput)
//   wdata     store data from the core (dataout)
//   wr        store strobe from the core
//   rdata     load data to the core (datain) = mem[addr], combinational
//   ext_req   store buffer non-empty; head entry valid on ext_addr/ext_data
//   ext_addr  head entry address (0 when empty)
//   ext_data  head entry data (0 when empty)
//   ext_ack   backing store accepted the head entry at this posedge
//   count     buffer occupancy, 0..DEPTH
//   overflow  sticky: a store was dropped from the buffer
module vsa_dmem_wbuf #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [AW-1:0]              addr,
  input  logic [DW-1:0]              wdata,
  input  logic                       wr,
  output logic [DW-1:0]              rdata,
  output logic                       ext_req,
  output logic [AW-1:0]              ext_addr,
  output logic [DW-1:0]              ext_data,
  input  logic                       ext_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned WORDS = 2**AW;

  logic [DW-1:0] mem      [WORDS];
  logic [AW-1:0] fifoAddr [DEPTH];
  logic [DW-1:0] fifoData [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          push;
  logic          pop;

  assign rdata = mem[addr];

  // Entry storage is never cleared; the head is masked to zero whenever the
  // buffer is empty, so stale contents are never visible.
  assign ext_req  = (count != '0);
  assign ext_addr = ext_req ? fifoAddr[rptr] : '0;
  assign ext_data = ext_req ? fifoData[rptr] : '0;

  assign full = (count == CW'(DEPTH));
  assign pop  = ext_req && ext_ack;
  // When full, a simultaneous pop frees the slot being written, so the store
  // is still accepted.
  assign push = wr && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifoAddr[wptr] <= addr;
      fifoData[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vsa_dmem_wbuf.sv
module tb_vsa_dmem_wbuf;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] addr;
  logic [4:0] wdata;
  logic       wr;
  logic [4:0] rdata;
  logic       ext_req;
  logic [4:0] ext_addr;
  logic [4:0] ext_data;
  logic       ext_ack;
  logic [2:0] count;
  logic       overflow;

  int nComp = 0;
  int nFail = 0;

  vsa_dmem_wbuf #(.AW(5), .DW(5), .DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .wr       (wr),
    .rdata    (rdata),
    .ext_req  (ext_req),
    .ext_addr (ext_addr),
    .ext_data (ext_data),
    .ext_ack  (ext_ack),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [4:0] a;
    logic [4:0] d;
    logic       ack;
    logic [4:0] ca;   // address presented for the rdata check
    logic [4:0] rd;
    logic       req;
    logic [4:0] ea;
    logic [4:0] ed;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic w, input logic [4:0] a,
                              input logic [4:0] d, input logic ack, input logic [4:0] ca,
                              input logic [4:0] rd, input logic req, input logic [4:0] ea,
                              input logic [4:0] ed, input logic [2:0] cnt, input logic ovf);
    vec_t v;
    v.rst = rst; v.wr = w; v.a = a; v.d = d; v.ack = ack; v.ca = ca; v.rd = rd;
    v.req = req; v.ea = ea; v.ed = ed; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic checkAllZero(input string nm);
    for (int i = 0; i < 32; i++) begin
      addr = 5'(i);
      #1;
      chk(nm, i, 32'(rdata), 32'd0);
    end
  endtask

  logic [9:0] sq[$];
  logic [9:0] head;

  initial begin
    reset = 1'b1; wr = 1'b0; addr = '0; wdata = '0; ext_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    checkAllZero("reset_rdata");
    chk("reset_req", 0, 32'(ext_req), 32'd0);
    chk("reset_cnt", 0, 32'(count), 32'd0);
    chk("reset_ovf", 0, 32'(overflow), 32'd0);
    chk("reset_eaddr", 0, 32'(ext_addr), 32'd0);
    chk("reset_edata", 0, 32'(ext_data), 32'd0);

    //            rst  wr   a      d      ack  ca     rd     req  ea     ed     cnt   ovf
    // Single store, hold, ack; then ack on empty buffer is ignored
    vq.push_back(mk(1'b0,1'b1,5'd5, 5'h13,1'b0,5'd5, 5'h13,1'b1,5'd5, 5'h13,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b0,5'd5, 5'h13,1'b1,5'd5, 5'h13,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b0,5'd5, 5'h13,1'b1,5'd5, 5'h13,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b0,5'd5, 5'h13,1'b1,5'd5, 5'h13,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd5, 5'h13,1'b0,5'd0, 5'h00,3'd0,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd5, 5'h13,1'b0,5'd0, 5'h00,3'd0,1'b0));
    // Fill, overflow store at 9, drain 1..4
    vq.push_back(mk(1'b0,1'b1,5'd1, 5'h11,1'b0,5'd1, 5'h11,1'b1,5'd1, 5'h11,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd2, 5'h12,1'b0,5'd2, 5'h12,1'b1,5'd1, 5'h11,3'd2,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd3, 5'h13,1'b0,5'd3, 5'h13,1'b1,5'd1, 5'h11,3'd3,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd4, 5'h14,1'b0,5'd4, 5'h14,1'b1,5'd1, 5'h11,3'd4,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd9, 5'h1F,1'b0,5'd9, 5'h1F,1'b1,5'd1, 5'h11,3'd4,1'b1));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd9, 5'h1F,1'b1,5'd2, 5'h12,3'd3,1'b1));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd9, 5'h1F,1'b1,5'd3, 5'h13,3'd2,1'b1));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd9, 5'h1F,1'b1,5'd4, 5'h14,3'd1,1'b1));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd9, 5'h1F,1'b0,5'd0, 5'h00,3'd0,1'b1));
    // Reset clears overflow and memory
    vq.push_back(mk(1'b1,1'b0,5'd0, 5'h00,1'b0,5'd9, 5'h00,1'b0,5'd0, 5'h00,3'd0,1'b0));
    // Full buffer, store at 7 with simultaneous ack
    vq.push_back(mk(1'b0,1'b1,5'd1, 5'h11,1'b0,5'd1, 5'h11,1'b1,5'd1, 5'h11,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd2, 5'h12,1'b0,5'd2, 5'h12,1'b1,5'd1, 5'h11,3'd2,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd3, 5'h13,1'b0,5'd3, 5'h13,1'b1,5'd1, 5'h11,3'd3,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd4, 5'h14,1'b0,5'd4, 5'h14,1'b1,5'd1, 5'h11,3'd4,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd7, 5'h07,1'b1,5'd7, 5'h07,1'b1,5'd2, 5'h12,3'd4,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd7, 5'h07,1'b1,5'd3, 5'h13,3'd3,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd7, 5'h07,1'b1,5'd4, 5'h14,3'd2,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd7, 5'h07,1'b1,5'd7, 5'h07,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd7, 5'h07,1'b0,5'd0, 5'h00,3'd0,1'b0));
    // Push+pop at count=1: head moves to the new entry
    vq.push_back(mk(1'b0,1'b1,5'd6, 5'h16,1'b0,5'd6, 5'h16,1'b1,5'd6, 5'h16,3'd1,1'b0));
    vq.push_back(mk(1'b0,1'b1,5'd8, 5'h18,1'b1,5'd8, 5'h18,1'b1,5'd8, 5'h18,3'd1,1'b0));
    // Two entries buffered, reset, then a stray ack
    vq.push_back(mk(1'b0,1'b1,5'd10,5'h0A,1'b0,5'd10,5'h0A,1'b1,5'd8, 5'h18,3'd2,1'b0));
    vq.push_back(mk(1'b1,1'b0,5'd0, 5'h00,1'b0,5'd8, 5'h00,1'b0,5'd0, 5'h00,3'd0,1'b0));
    vq.push_back(mk(1'b0,1'b0,5'd0, 5'h00,1'b1,5'd10,5'h00,1'b0,5'd0, 5'h00,3'd0,1'b0));

    foreach (vq[i]) begin
      @(negedge clock);
      reset = vq[i].rst; wr = vq[i].wr; addr = vq[i].a; wdata = vq[i].d;
      ext_ack = vq[i].ack;
      @(posedge clock);
      #1;
      reset = 1'b0; wr = 1'b0; ext_ack = 1'b0; addr = vq[i].ca;
      #1;
      chk("rdata", i, 32'(rdata), 32'(vq[i].rd));
      chk("ext_req", i, 32'(ext_req), 32'(vq[i].req));
      chk("ext_addr", i, 32'(ext_addr), 32'(vq[i].ea));
      chk("ext_data", i, 32'(ext_data), 32'(vq[i].ed));
      chk("count", i, 32'(count), 32'(vq[i].cnt));
      chk("overflow", i, 32'(overflow), 32'(vq[i].ovf));
    end
    checkAllZero("post_reset_rdata");

    // Six wraps at a 5-cycle store cadence with ack gaps of 0..3 idle cycles
    begin
      int unsigned gap = 0;
      int stores = 0;
      int pops = 0;
      int cyc = 0;
      while ((stores < 24 || sq.size() != 0) && cyc < 400) begin
        @(negedge clock);
        wr = 1'b0; ext_ack = 1'b0;
        if (ext_req) begin
          if (gap == 0) begin
            ext_ack = 1'b1;
            if (sq.size() == 0) begin
              chk("stream_unexpected", pops, 32'(ext_req), 32'd0);
            end else begin
              head = sq.pop_front();
              chk("stream_addr", pops, 32'(ext_addr), 32'(head[9:5]));
              chk("stream_data", pops, 32'(ext_data), 32'(head[4:0]));
            end
            pops++;
            gap = $urandom_range(0, 3);
          end else begin
            gap--;
          end
        end
        if (stores < 24 && (cyc % 5) == 0) begin
          wr = 1'b1;
          addr = 5'($urandom_range(0, 31));
          wdata = 5'($urandom_range(0, 31));
          sq.push_back({addr, wdata});
          stores++;
        end
        cyc++;
      end
      @(negedge clock);
      wr = 1'b0; ext_ack = 1'b0;
      chk("stream_timeout", cyc, 32'(cyc < 400), 32'd1);
      chk("stream_pops", 0, 32'(pops), 32'd24);
      chk("stream_ovf", 0, 32'(overflow), 32'd0);
      chk("stream_cnt", 0, 32'(count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nComp, nFail);
    $finish;
  end

endmodule
